// File: rtl/gpp_dbg_pkg.sv
// Shared definitions for the gpp_calc debug unit.
// Holds the command opcodes, the controller FSM state encoding and the
// bit positions of the core flags inside the 4-bit {O,C,N,Z} flag vector.
package gpp_dbg_pkg;

  localparam logic [1:0] OP_NOP       = 2'd0;
  localparam logic [1:0] OP_CLEAR     = 2'd1;
  localparam logic [1:0] OP_DUMP_REGS = 2'd2;
  localparam logic [1:0] OP_DUMP_MEM  = 2'd3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_CLR,
    ST_REGS,
    ST_MEM_RD,
    ST_MEM_WAIT,
    ST_MEM_EMIT,
    ST_FINISH
  } dbg_state_t;

endpackage

// File: rtl/gpp_debug_unit_if.sv
// Command and stream bundle of the debug unit.
// master: the host side (issues commands, consumes the word stream).
// slave:  the debug unit (accepts commands, produces the word stream).
//   cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_len : command handshake
//   out_valid/out_ready/out_data/out_tag/out_last : dump word stream
interface gpp_debug_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_len;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_tag;
  logic              out_last;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_tag, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_tag, out_last
  );
endinterface

// File: rtl/gpp_dbg_stream_reg.sv
// Output holding register for the dump stream.
// Ports: clk/rst; load + load_data/load_tag/load_last offer a new word;
// ready from the consumer; valid/data/tag/last drive the stream; fire marks
// the edge on which the held word transfers.
// A word stays frozen while valid is high until it has been taken.
module gpp_dbg_stream_reg #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag,
  output logic              last,
  output logic              fire
);

  logic accept;

  assign fire   = valid & ready;
  // A new word may only replace the held one once it has been consumed.
  assign accept = load & (~valid | fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
      last  <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      data  <= load_data;
      tag   <= load_tag;
      last  <= load_last;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gpp_debug_unit.sv
// Debug/inspection controller for the gpp_calc core family.
// Ports: clk/rst; dbg (command + dump stream bundle, slave side);
// halt_req/halt_ack core stall handshake; reg_bus/flags core state;
// mem_addr/mem_we/mem_wdata/mem_rdata second data-memory port;
// busy (not idle) and done (one-cycle completion pulse).
module gpp_debug_unit
  import gpp_dbg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int NREG   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  gpp_debug_unit_if.slave        dbg,
  output logic                   halt_req,
  input  logic                   halt_ack,
  input  logic [NREG*DATA_W-1:0] reg_bus,
  input  logic [3:0]             flags,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int IDX_W = $clog2(NREG + 1);

  dbg_state_t        state, next_state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remain_q;
  logic [IDX_W-1:0]  idx_q;

  logic              cmd_take, addr_step, idx_step, wr_en;
  logic              load, ld_last, fire;
  logic [DATA_W-1:0] ld_data, reg_word, flag_word;
  logic [ADDR_W-1:0] ld_tag;

  // Register-file word selected by idx_q; the slot after the last register is the flags word.
  always_comb begin
    flag_word         = '0;
    flag_word[FLAG_Z] = flags[FLAG_Z];
    flag_word[FLAG_N] = flags[FLAG_N];
    flag_word[FLAG_C] = flags[FLAG_C];
    flag_word[FLAG_O] = flags[FLAG_O];
    reg_word          = flag_word;
    for (int i = 0; i < NREG; i++) begin
      if (idx_q == IDX_W'(i)) reg_word = reg_bus[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_take   = 1'b0;
    addr_step  = 1'b0;
    idx_step   = 1'b0;
    load       = 1'b0;
    ld_data    = '0;
    ld_tag     = '0;
    ld_last    = 1'b0;
    halt_req   = 1'b0;
    wr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg.cmd_valid) begin
          cmd_take   = 1'b1;
          next_state = (dbg.cmd_op == OP_NOP) ? ST_FINISH : ST_HALT;
        end
      end
      ST_HALT: begin
        halt_req = 1'b1;
        if (halt_ack) begin
          case (op_q)
            OP_CLEAR:     next_state = ST_CLR;
            OP_DUMP_REGS: next_state = ST_REGS;
            default:      next_state = ST_MEM_RD;
          endcase
        end
      end
      ST_CLR: begin
        halt_req  = 1'b1;
        wr_en     = 1'b1;
        addr_step = 1'b1;
        if (remain_q == CNT_W'(1)) next_state = ST_FINISH;
      end
      ST_REGS: begin
        // One word in flight at a time; finish once the flags word is taken.
        halt_req = 1'b1;
        if (!dbg.out_valid) begin
          load     = 1'b1;
          ld_data  = reg_word;
          ld_tag   = ADDR_W'(idx_q);
          ld_last  = (idx_q == IDX_W'(NREG));
          idx_step = 1'b1;
        end else if (fire && dbg.out_last) begin
          next_state = ST_FINISH;
        end
      end
      ST_MEM_RD: begin
        halt_req   = 1'b1;
        next_state = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        halt_req   = 1'b1;
        load       = 1'b1;
        ld_data    = mem_rdata;
        ld_tag     = addr_q;
        ld_last    = (remain_q == CNT_W'(1));
        next_state = ST_MEM_EMIT;
      end
      ST_MEM_EMIT: begin
        halt_req = 1'b1;
        if (fire) begin
          if (remain_q == CNT_W'(1)) begin
            next_state = ST_FINISH;
          end else begin
            addr_step  = 1'b1;
            next_state = ST_MEM_RD;
          end
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Length 0 encodes a full sweep of memory, hence the extra counter bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NOP;
      addr_q   <= '0;
      remain_q <= '0;
      idx_q    <= '0;
    end else if (cmd_take) begin
      op_q     <= dbg.cmd_op;
      addr_q   <= dbg.cmd_base;
      remain_q <= (dbg.cmd_len == '0) ? (CNT_W'(1) << ADDR_W) : {1'b0, dbg.cmd_len};
      idx_q    <= '0;
    end else begin
      if (addr_step) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - CNT_W'(1);
      end
      if (idx_step) idx_q <= idx_q + IDX_W'(1);
    end
  end

  // The write strobe is cut as soon as reset is seen so an abort loses no extra word.
  assign mem_we        = wr_en & ~rst;
  assign mem_addr      = addr_q;
  assign mem_wdata     = '0;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_FINISH);
  assign dbg.cmd_ready = (state == ST_IDLE);

  gpp_dbg_stream_reg #(.DATA_W(DATA_W), .TAG_W(ADDR_W)) u_stream (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (ld_data),
    .load_tag  (ld_tag),
    .load_last (ld_last),
    .ready     (dbg.out_ready),
    .valid     (dbg.out_valid),
    .data      (dbg.out_data),
    .tag       (dbg.out_tag),
    .last      (dbg.out_last),
    .fire      (fire)
  );

endmodule

// File: tb/tb_gpp_debug_unit.sv
// Directed testbench for gpp_debug_unit: reset, NOP, register dump,
// memory dumps (short with back-pressure, full sweep), clear, aborted clear.
module tb_gpp_debug_unit;
  import gpp_dbg_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int NREG   = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ACK_DELAY = 2;

  logic clk = 1'b0;
  logic rst;
  logic halt_req, halt_ack;
  logic [NREG*DATA_W-1:0] reg_bus;
  logic [3:0] flags;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic busy, done;
  logic init_req;

  logic [DATA_W-1:0] mem [DEPTH];
  int ack_cnt;
  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] got_data[$];
  logic [ADDR_W-1:0] got_tag[$];
  logic              got_last[$];

  gpp_debug_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dbg_if ();

  gpp_debug_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .dbg       (dbg_if.slave),
    .halt_req  (halt_req),
    .halt_ack  (halt_ack),
    .reg_bus   (reg_bus),
    .flags     (flags),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return DATA_W'((i + 1) * 11);
  endfunction

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Core model: acknowledges a stall a few cycles after it is requested.
  always @(posedge clk) begin
    if (!halt_req) begin
      ack_cnt  <= 0;
      halt_ack <= 1'b0;
    end else if (ack_cnt == ACK_DELAY) begin
      halt_ack <= 1'b1;
    end else begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command; returns just after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input int base, input int len);
    @(negedge clk);
    dbg_if.cmd_op    = op;
    dbg_if.cmd_base  = ADDR_W'(base);
    dbg_if.cmd_len   = ADDR_W'(len);
    dbg_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 dbg_if.cmd_valid = 1'b0;
  endtask

  // Gather stream words until done pulses, checking the hold-stable rule on stalls.
  task automatic collectStream(input bit toggle, input int budget);
    bit seen_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    logic [ADDR_W-1:0] pt = '0;
    logic pl = 1'b0;
    got_data.delete();
    got_tag.delete();
    got_last.delete();
    dbg_if.out_ready = 1'b1;
    for (int c = 0; c < budget && !seen_done; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      dbg_if.out_ready = toggle ? ~dbg_if.out_ready : 1'b1;
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(dbg_if.out_valid), 32'd1);
        checkOutput("hold_data", 32'(dbg_if.out_data), 32'(pd));
        checkOutput("hold_tag", 32'(dbg_if.out_tag), 32'(pt));
        checkOutput("hold_last", 32'(dbg_if.out_last), 32'(pl));
      end
      prev_stall = dbg_if.out_valid && !dbg_if.out_ready;
      pd = dbg_if.out_data;
      pt = dbg_if.out_tag;
      pl = dbg_if.out_last;
      if (dbg_if.out_valid && dbg_if.out_ready) begin
        got_data.push_back(dbg_if.out_data);
        got_tag.push_back(dbg_if.out_tag);
        got_last.push_back(dbg_if.out_last);
      end
    end
    checkOutput("done_seen", 32'(seen_done), 32'd1);
    dbg_if.out_ready = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_regs [4];
    int n;
    int wr_addr[$];
    int wr_cyc[$];
    bit seen_done;
    int writes;

    rst = 1'b1;
    init_req = 1'b1;
    reg_bus = '0;
    flags = '0;
    dbg_if.out_ready = 1'b1;
    dbg_if.cmd_valid = 1'b1;
    dbg_if.cmd_op    = OP_DUMP_REGS;
    dbg_if.cmd_base  = '0;
    dbg_if.cmd_len   = '0;

    // Reset with a command pending: nothing may be accepted.
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(dbg_if.cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_halt_req", 32'(halt_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_out_valid", 32'(dbg_if.out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(dbg_if.out_last), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_out_data", 32'(dbg_if.out_data), 32'd0);
    checkOutput("rst_out_tag", 32'(dbg_if.out_tag), 32'd0);
    dbg_if.cmd_valid = 1'b0;
    rst = 1'b0;
    init_req = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(dbg_if.cmd_ready), 32'd1);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    // NOP: done next cycle, no stall.
    applyStimulus(OP_NOP, 0, 0);
    @(negedge clk);
    checkOutput("nop_done", 32'(done), 32'd1);
    checkOutput("nop_halt_req", 32'(halt_req), 32'd0);
    @(negedge clk);
    checkOutput("nop_done_clear", 32'(done), 32'd0);
    checkOutput("nop_cmd_ready", 32'(dbg_if.cmd_ready), 32'd1);

    // Register dump.
    reg_bus = {16'd7, 16'hFFFF, 16'd5};
    flags = 4'b0101;
    exp_regs = '{16'd5, 16'hFFFF, 16'd7, 16'h0005};
    applyStimulus(OP_DUMP_REGS, 0, 0);
    collectStream(1'b0, 100);
    checkOutput("regs_count", 32'(got_data.size()), 32'd4);
    n = (got_data.size() < 4) ? got_data.size() : 4;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("regs_data%0d", i), 32'(got_data[i]), 32'(exp_regs[i]));
      checkOutput($sformatf("regs_tag%0d", i), 32'(got_tag[i]), 32'(i));
      checkOutput($sformatf("regs_last%0d", i), 32'(got_last[i]), 32'(i == 3));
    end
    checkOutput("regs_halt_released", 32'(halt_req), 32'd0);

    // Short memory dump with back-pressure.
    applyStimulus(OP_DUMP_MEM, 0, 3);
    collectStream(1'b1, 200);
    checkOutput("mem3_count", 32'(got_data.size()), 32'd3);
    n = (got_data.size() < 3) ? got_data.size() : 3;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("mem3_data%0d", i), 32'(got_data[i]), 32'((i + 1) * 11));
      checkOutput($sformatf("mem3_tag%0d", i), 32'(got_tag[i]), 32'(i));
      checkOutput($sformatf("mem3_last%0d", i), 32'(got_last[i]), 32'(i == 2));
    end

    // Full-sweep memory dump (length 0).
    applyStimulus(OP_DUMP_MEM, 0, 0);
    collectStream(1'b0, 3000);
    checkOutput("memall_count", 32'(got_data.size()), 32'(DEPTH));
    n = (got_data.size() < DEPTH) ? got_data.size() : DEPTH;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("memall_data%0d", i), 32'(got_data[i]), 32'(pattern(i)));
      checkOutput($sformatf("memall_tag%0d", i), 32'(got_tag[i]), 32'(i));
      checkOutput($sformatf("memall_last%0d", i), 32'(got_last[i]), 32'(i == DEPTH - 1));
    end

    // Clear across the top of memory.
    applyStimulus(OP_CLEAR, 510, 4);
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wr_addr.push_back(int'(mem_addr));
        wr_cyc.push_back(c);
        checkOutput("clr_wdata", 32'(mem_wdata), 32'd0);
      end
      if (done) begin
        seen_done = 1'b1;
        checkOutput("clr_done_after_writes", 32'(c), 32'(wr_cyc.size() > 0 ? wr_cyc[$] + 1 : -1));
        checkOutput("clr_halt_released", 32'(halt_req), 32'd0);
      end
    end
    checkOutput("clr_done_seen", 32'(seen_done), 32'd1);
    checkOutput("clr_writes", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      checkOutput("clr_addr0", 32'(wr_addr[0]), 32'd510);
      checkOutput("clr_addr1", 32'(wr_addr[1]), 32'd511);
      checkOutput("clr_addr2", 32'(wr_addr[2]), 32'd0);
      checkOutput("clr_addr3", 32'(wr_addr[3]), 32'd1);
      checkOutput("clr_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    end
    checkOutput("clr_mem510", 32'(mem[510]), 32'd0);
    checkOutput("clr_mem1", 32'(mem[1]), 32'd0);
    checkOutput("clr_mem2_kept", 32'(mem[2]), 32'd33);
    checkOutput("clr_mem509_kept", 32'(mem[509]), 32'(pattern(509)));

    // Reset in the middle of a clear, after two writes.
    applyStimulus(OP_CLEAR, 100, 8);
    writes = 0;
    for (int c = 0; c < 40 && writes < 2; c++) begin
      @(negedge clk);
      if (mem_we) writes++;
    end
    checkOutput("abort_two_writes", 32'(writes), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_we_cut", 32'(mem_we), 32'd0);
    @(negedge clk);
    checkOutput("abort_halt_req", 32'(halt_req), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cmd_ready", 32'(dbg_if.cmd_ready), 32'd1);
    rst = 1'b0;
    writes = 0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we) writes++;
      if (done) seen_done = 1'b1;
    end
    checkOutput("abort_no_more_writes", 32'(writes), 32'd0);
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);
    checkOutput("abort_mem100", 32'(mem[100]), 32'd0);
    checkOutput("abort_mem101", 32'(mem[101]), 32'd0);
    checkOutput("abort_mem102_kept", 32'(mem[102]), 32'(pattern(102)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gpp_debug_unit.md
Name: gpp_debug_unit

Overview:
Synthesizable debug/inspection controller for the gpp_calc core family, generalised over data width, memory depth and architectural register count. It accepts commands to clear data memory, dump the register file plus flags, or dump a data-memory window as a valid/ready word stream. The core is halted via a req/ack handshake for the duration of every memory or register access. It sits beside the core and connects to a second data-memory port and to the register/flag outputs.

Parameters:
DATA_W, 16, data word and register width
ADDR_W, 9, data-memory address width; depth = 2**ADDR_W
NREG, 3, architectural registers exposed (ACC, X, Y order)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0 NOP, 1 CLEAR, 2 DUMP_REGS, 3 DUMP_MEM
cmd_base  in  ADDR_W  start address for CLEAR/DUMP_MEM
cmd_len  in  ADDR_W  word count; 0 means 2**ADDR_W
halt_req  out  1  request core stall
halt_ack  in  1  core stalled
reg_bus  in  NREG*DATA_W  register values, reg0 in LSBs
flags  in  4  {O,C,N,Z}
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  write data (always 0)
mem_rdata  in  DATA_W  read data, valid 1 cycle after address
out_valid  out  1  stream word valid
out_ready  in  1  stream consumer ready
out_data  out  DATA_W  stream word
out_tag  out  ADDR_W  register index or memory address of word
out_last  out  1  final word of a dump
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset: state IDLE; cmd_ready=1; halt_req, mem_we, out_valid, out_last, busy, done = 0; mem_addr, out_data, out_tag = 0. Reset mid-command aborts immediately: no further writes, stream word dropped, halt released.
- Command accepted on a clk edge with cmd_valid&cmd_ready; op/base/len latched. len==0 is expanded to 2**ADDR_W (internal counter ADDR_W+1 bits).
- NOP: IDLE->FINISH; done pulses the next cycle; halt_req never asserted.
- Other ops: IDLE->HALT; halt_req=1 and held until FINISH; wait for halt_ack=1 (no timeout).
- CLEAR: CLR state writes 0 at base, base+1, ... one word per cycle, mem_we=1 for exactly len cycles; addresses wrap modulo 2**ADDR_W.
- DUMP_REGS: emits NREG+1 words: reg i (tag=i) for i=0..NREG-1, then flags zero-extended to DATA_W (tag=NREG); out_last on the flags word.
- DUMP_MEM: loop MEM_RD (drive mem_addr) -> MEM_WAIT (capture mem_rdata) -> MEM_EMIT (out_valid=1, tag=address) until out_ready; addresses wrap; out_last on the len-th word.
- Stream rule: while out_valid=1, out_data/out_tag/out_last hold stable until out_ready is seen high; the word transfers on the edge where both are high; out_valid falls next cycle unless another word follows.
- FINISH: halt_req=0, done=1 for one cycle, then IDLE. Core release is not gated on halt_ack falling.
- halt_ack dropping mid-command is ignored (core is contractually stalled).
- mem_we is never high outside CLR; the write and read paths share mem_addr.

Decomposition:
- Package gpp_dbg_pkg: opcode constants (OP_NOP, OP_CLEAR, OP_DUMP_REGS, OP_DUMP_MEM), FSM state encoding, flag bit positions.
- One sub-module: gpp_dbg_stream_reg, the output holding register implementing the valid/ready hold-stable rule; FSM and address/length counters stay in the top.

Test Plan:
- Reset with cmd_valid=1 held -> no command accepted during reset; all outputs at reset values; cmd_ready=1 the first cycle after rst falls.
- CLEAR base=510 len=4, halt_ack 3 cycles after halt_req -> mem_we high 4 consecutive cycles at addresses 510,511,0,1; done 1 cycle later; halt_req low again.
- DUMP_REGS with ACC=5, X=0xFFFF, Y=7, flags Z=1,C=1 -> words 5,0xFFFF,7,0x0005 with tags 0..3; out_last only on tag 3.
- DUMP_MEM base=0 len=3, mem[0..2]=11,22,33, out_ready toggled 1/0 each cycle -> exactly 11,22,33 delivered in order; data stable while stalled; no duplicates.
- DUMP_MEM len=0 -> 512 words, tags 0..511, out_last on tag 511.
- rst asserted mid-CLEAR after 2 writes -> no further mem_we; halt_req=0 and busy=0 the next cycle; done never pulses.
